inst_fetch: RTL and testbench

- Initiator side of the instruction-memory interface. It owns the program counter and drives the ROM chip-enable and byte address.
- It samples the combinational ROM instruction return in the same cycle and registers PC and instruction into the IF/ID stage for decode.
- It handles pipeline stall, exception flush and MIPS branch redirection, including a branch that arrives while the pipeline is stalled.

---
 rtl/inst_fetch.sv | 199 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage: the initiator side of the instruction-memory
// interface. Owns the program counter, drives the ROM chip-enable and byte
// address, samples the combinational ROM return in the same cycle and
// registers {PC, instruction} into the IF/ID stage for decode.
//
// Handles pipeline stall, exception flush and MIPS-style branch redirection.
// A taken branch that resolves while the pipeline is stalled is remembered in
// a pending register and applied on the first unstalled edge. The instruction
// fetched in the branch cycle is the delay slot and is never killed.
//
// Parameters
//   ADDR_W   - width of PC / ROM address bus
//   INST_W   - width of instruction word
//   RESET_PC - first fetch address after reset
//
// Ports
//   clk             in   pipeline clock, rising edge
//   rst             in   asynchronous, active-low reset
//   stall_i         in   hold PC and IF/ID
//   flush_i         in   exception flush: redirect to new_pc_i, kill IF/ID
//   new_pc_i        in   exception handler / ERET target
//   branch_flag_i   in   branch/jump resolved taken in decode
//   branch_target_i in   branch/jump target
//   rom_ce_o        out  ROM chip enable
//   rom_addr_o      out  byte fetch address (= PC)
//   rom_inst_i      in   ROM read data, combinational from rom_addr_o
//   id_pc_o         out  PC of the instruction held in IF/ID
//   id_inst_o       out  instruction held in IF/ID
//   id_valid_o      out  IF/ID holds a real fetched instruction
//
// Optional feature (macro INST_FETCH_PERF_EN)
//   fetch_cnt_o     out  32-bit count of unstalled, unflushed fetch edges
//   stall_cnt_o     out  32-bit count of stalled edges
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  // Source of the next PC, in priority order. IDLE covers the start-up
  // cycle(s) before the chip enable has come up.
  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_FLUSH,
    SEL_STALL,
    SEL_PEND,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  // Redirect targets are forced word-aligned.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    align = {a[ADDR_W-1:2], 2'b00};
  endfunction

  pc_sel_e           pc_sel;

  logic              ce_q;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic              pend_q,     pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [ADDR_W-1:0] id_pc_d;
  logic [INST_W-1:0] id_inst_d;
  logic              id_valid_d;

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_sel = SEL_IDLE;
    if (ce_q) begin
      if (flush_i)            pc_sel = SEL_FLUSH;
      else if (stall_i)       pc_sel = SEL_STALL;
      else if (pend_q)        pc_sel = SEL_PEND;
      else if (branch_flag_i) pc_sel = SEL_BRANCH;
      else                    pc_sel = SEL_SEQ;
    end
  end

  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no
    // path through the case below can leave it unassigned and infer a latch.
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    unique case (pc_sel)
      SEL_IDLE: ;
      SEL_FLUSH: begin
        // An exception discards any branch remembered during a stall.
        pc_d   = align(new_pc_i);
        pend_d = 1'b0;
      end
      SEL_STALL: begin
        // PC holds; a branch resolving now is remembered. A later branch in
        // the same stall overwrites the earlier target.
        if (branch_flag_i) begin
          pend_d     = 1'b1;
          pend_tgt_d = align(branch_target_i);
        end
      end
      SEL_PEND: begin
        pc_d   = pend_tgt_q;
        pend_d = 1'b0;
      end
      SEL_BRANCH: pc_d = align(branch_target_i);
      SEL_SEQ:    pc_d = pc_q + ADDR_W'(4);  // wraps modulo 2^ADDR_W
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // IF/ID next value. The delay-slot instruction (fetched while the branch is
  // being taken) is loaded like any other; only flush kills the stage.
  // ---------------------------------------------------------------------------
  always_comb begin
    id_pc_d    = id_pc_o;
    id_inst_d  = id_inst_o;
    id_valid_d = id_valid_o;
    if (flush_i) begin
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      id_pc_d    = pc_q;
      // Before the ROM is enabled its return is meaningless: insert a bubble.
      id_inst_d  = ce_q ? rom_inst_i : '0;
      id_valid_d = ce_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q       <= 1'b0;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
    end else begin
      // Chip enable comes up on the first edge after reset and stays up.
      ce_q       <= 1'b1;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      id_pc_o    <= id_pc_d;
      id_inst_o  <= id_inst_d;
      id_valid_o <= id_valid_d;
    end
  end

`ifdef INST_FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters; both wrap silently.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (ce_q && !stall_i && !flush_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (ce_q && stall_i)              stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed bench for inst_fetch. A combinational ROM model returns a word
// derived from the address, so every captured instruction can be predicted.
// Expected values are hand-derived and written inline at each step.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef INST_FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;
  logic        ce_m;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    rom = {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign rom_inst_i = rom(rom_addr_o);

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_inst_i      (rom_inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
`ifdef INST_FETCH_PERF_EN
    ,
    .fetch_cnt_o     (fetch_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
`ifdef INST_FETCH_PERF_EN
    if (ce_m && !stall_i && !flush_i) exp_fetch = exp_fetch + 32'd1;
    if (ce_m && stall_i)              exp_stall = exp_stall + 32'd1;
`endif
    @(posedge clk);
    #1;
`ifdef INST_FETCH_PERF_EN
    ce_m = 1'b1;
`endif
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic valid);
    check({tag, ".id_pc"},    id_pc_o,           pc);
    check({tag, ".id_inst"},  id_inst_o,         valid ? rom(pc) : 32'h0);
    check({tag, ".id_valid"}, {31'b0, id_valid_o}, {31'b0, valid});
  endtask

`ifdef INST_FETCH_PERF_EN
  task automatic check_perf(input string tag);
    check({tag, ".fetch_cnt"}, fetch_cnt_o, exp_fetch);
    check({tag, ".stall_cnt"}, stall_cnt_o, exp_stall);
  endtask
`endif

  initial begin
    rst             = 1'b0;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    new_pc_i        = '0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
`ifdef INST_FETCH_PERF_EN
    exp_fetch = '0;
    exp_stall = '0;
    ce_m      = 1'b0;
`endif

    // Reset state, clock running.
    repeat (2) @(posedge clk);
    #1;
    check("rst.ce",   {31'b0, rom_ce_o}, 32'h0);
    check("rst.addr", rom_addr_o, 32'h0);
    check_id("rst", 32'h0, 1'b0);
`ifdef INST_FETCH_PERF_EN
    check_perf("rst");
`endif
    rst = 1'b1;

    // Start-up: chip enable rises, PC still at reset value, IF/ID bubble.
    step();
    check("start.ce",   {31'b0, rom_ce_o}, 32'h1);
    check("start.addr", rom_addr_o, 32'h0);
    check_id("start", 32'h0, 1'b0);

    step();
    check("seq.addr4", rom_addr_o, 32'h4);
    check_id("seq.0", 32'h0, 1'b1);
    step();
    check("seq.addr8", rom_addr_o, 32'h8);
    check_id("seq.4", 32'h4, 1'b1);

    // Three-cycle stall at PC=8.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", rom_addr_o, 32'h8);
      check_id("stall", 32'h4, 1'b1);
    end
    stall_i = 1'b0;
    step();
    check("resume.addr", rom_addr_o, 32'hC);
    check_id("resume", 32'h8, 1'b1);
`ifdef INST_FETCH_PERF_EN
    check_perf("resume");
`endif
    step();
    check("seq.addr10", rom_addr_o, 32'h10);

    // Branch at PC=10 to 40: 10 is the delay slot.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h40;
    step();
    branch_flag_i = 1'b0;
    check("br.addr40", rom_addr_o, 32'h40);
    check_id("br.slot", 32'h10, 1'b1);
    step();
    check("br.addr44", rom_addr_o, 32'h44);
    check_id("br.40", 32'h40, 1'b1);

    // Misaligned branch target 22 lands at 20.
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h22;
    step();
    check("align.addr20", rom_addr_o, 32'h20);

    // Branch during stall at PC=20; second branch in stall overwrites (83->80).
    stall_i         = 1'b1;
    branch_target_i = 32'h60;
    step();
    check("pend.hold1", rom_addr_o, 32'h20);
    check_id("pend.hold1", 32'h44, 1'b1);
    branch_target_i = 32'h83;
    step();
    check("pend.hold2", rom_addr_o, 32'h20);
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    step();
    check("pend.addr80", rom_addr_o, 32'h80);
    check_id("pend.rel", 32'h20, 1'b1);
    step();
    check("pend.addr84", rom_addr_o, 32'h84);
    check_id("pend.80", 32'h80, 1'b1);

    // Pending branch then flush+stall: flush wins and discards pending.
    stall_i         = 1'b1;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h100;
    step();
    check("fl.hold", rom_addr_o, 32'h84);
    branch_flag_i = 1'b0;
    flush_i       = 1'b1;
    new_pc_i      = 32'h0000_0183;
    step();
    check("fl.addr180", rom_addr_o, 32'h180);
    check_id("fl.kill", 32'h0, 1'b0);
    flush_i = 1'b0;
    stall_i = 1'b0;
    step();
    check("fl.addr184", rom_addr_o, 32'h184);
    check_id("fl.180", 32'h180, 1'b1);

    // PC wrap from FFFF_FFFC to 0.
    flush_i  = 1'b1;
    new_pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0;
    check("wrap.top", rom_addr_o, 32'hFFFF_FFFC);
    step();
    check("wrap.addr0", rom_addr_o, 32'h0);
    check_id("wrap.top", 32'hFFFF_FFFC, 1'b1);
    step();
    check("wrap.addr4", rom_addr_o, 32'h4);
    check_id("wrap.0", 32'h0, 1'b1);
`ifdef INST_FETCH_PERF_EN
    check_perf("wrap");
`endif

    // Asynchronous reset mid-operation, away from any clock edge.
    #3;
    rst = 1'b0;
`ifdef INST_FETCH_PERF_EN
    exp_fetch = '0;
    exp_stall = '0;
    ce_m      = 1'b0;
`endif
    #1;
    check("arst.ce",   {31'b0, rom_ce_o}, 32'h0);
    check("arst.addr", rom_addr_o, 32'h0);
    check_id("arst", 32'h0, 1'b0);
`ifdef INST_FETCH_PERF_EN
    check_perf("arst");
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rest.ce",   {31'b0, rom_ce_o}, 32'h1);
    check("rest.addr", rom_addr_o, 32'h0);
    step();
    check("rest.addr4", rom_addr_o, 32'h4);
    check_id("rest.0", 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
